tx_frame_serializer: RTL and testbench
======================================

// Module: tx_frame_serializer
// PURPOSE
//   Transmit-side serializer for the UART path. Accepts parallel bytes over a
//   valid/ready handshake into a one-entry hold buffer, then frames each byte
//   (start, LSB-first data, optional parity, stop) onto the serial line.
//   Advances exactly one bit per bit_tick, the shift strobe from the transmit
//   bit-sample counter, and drives count_enable to keep that counter running.
// PARAMETERS
//   DATA_W      8   data bits per frame (5..9)
//   PARITY_EN   0   1 = insert parity bit after data
//   PARITY_ODD  0   1 = odd parity, 0 = even (only used when PARITY_EN=1)
//   STOP_BITS   1   number of stop bits (1 or 2)
// PORTS
//   clk           in   1       system clock; all state updates on posedge
//   reset         in   1       synchronous, active-low reset
//   tx_data       in   DATA_W  byte to send; sampled when tx_valid && tx_ready
//   tx_valid      in   1       upstream has data
//   tx_ready      out  1       hold buffer empty; transfer when valid && ready
//   bit_tick      in   1       1-cycle strobe per bit period from bit counter
//   count_enable  out  1       high while a frame is in flight
//   serial_out    out  1       serial line; idles high
//   busy          out  1       state != IDLE
//   frame_done    out  1       1-cycle pulse at end of last stop bit
// BEHAVIOUR
//   Reset (reset==0 at posedge): state=IDLE, hold empty, serial_out=1,
//     count_enable=0, busy=0, frame_done=0, tx_ready=1. Applies mid-frame:
//     frame is abandoned, line returns high on that edge, held byte discarded.
//   Hold buffer: tx_ready = !hold_full (registered flag). Accept at edge N sets
//     hold_full; no accept possible while full (no same-cycle refill).
//   FSM states IDLE, START, DATA, PARITY, STOP; all outputs registered.
//   IDLE: serial_out=1; bit_tick ignored. If hold_full: load shifter from hold,
//     clear hold_full, go START. Accept at N -> start bit visible after N+2.
//   START: serial_out=0. On bit_tick -> DATA, bit_idx=0.
//   DATA: serial_out=shifter[0]. On bit_tick shift right, bit_idx++;
//     on tick with bit_idx==DATA_W-1 -> PARITY if PARITY_EN, else STOP.
//   PARITY: serial_out = ^data (even) or ~^data (odd), computed on load.
//     On bit_tick -> STOP, stop_cnt=0.
//   STOP: serial_out=1. On bit_tick stop_cnt++; on tick with
//     stop_cnt==STOP_BITS-1: frame_done=1 for one cycle; if hold_full,
//     reload and go directly to START (back-to-back, no idle bit), else IDLE.
//   count_enable=1 in START..STOP (asserted the edge START is entered,
//     cleared the edge IDLE is entered).
//   bit_tick and accept in same cycle are independent; both take effect.
//   bit_idx width $clog2(DATA_W); stop_cnt 1 bit; no wrap beyond terminal.
// STRUCTURE
//   Package tx_pkg: state enum tx_state_t {IDLE,START,DATA,PARITY,STOP},
//     localparams LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
//   Sub-module tx_hold_reg: one-entry valid/ready buffer (data, full flag,
//     load/pop). FSM, shifter, and parity live in the top.
// TESTING
//   1 Reset then idle 20 cycles, random bit_tick -> serial_out=1, tx_ready=1,
//     count_enable=0, busy=0 throughout.
//   2 Send 0xA5, 8N1, tick every 16 clk -> line 0,1,0,1,0,0,1,0,1,1;
//     one frame_done pulse; count_enable low afterwards.
//   3 PARITY_EN=1: 0x07 even -> parity bit 1; PARITY_ODD=1 -> parity bit 0.
//   4 Two bytes 0x3C,0xC3 offered back-to-back -> second accepted while first
//     shifts; stop of frame 1 followed directly by start of frame 2, no idle bit.
//   5 STOP_BITS=2 -> two high bit periods before frame_done / next start bit.
//   6 reset=0 during DATA bit 3 -> next edge serial_out=1, IDLE, tx_ready=1,
//     held byte dropped, no frame_done.

Source files
------------

// File: rtl/tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tx_pkg : shared state encoding and line levels for the UART TX path   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/tx_hold_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tx_hold_reg : one-entry valid/ready hold buffer in front of the FSM   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tx_hold_reg #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic              i_pop,
   output logic              o_full,
   output logic [DATA_W-1:0] o_data
);

   logic              r_full;
   logic [DATA_W-1:0] r_data;
   logic              w_load;

   // Ready comes straight from the flag, so a pop never reopens the slot in the same cycle.
   assign w_load  = i_valid && !r_full;
   assign o_ready = !r_full;
   assign o_full  = r_full;
   assign o_data  = r_data;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_full <= 1'b0;
         r_data <= '0;
      end else if (w_load) begin
         r_full <= 1'b1;
         r_data <= i_data;
      end else if (i_pop) begin
         r_full <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/tx_frame_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tx_frame_serializer : frames held bytes onto the UART line, one bit   |
// | per bit_tick (start, LSB-first data, optional parity, stop). Rev 1.0  |
// +----------------------------------------------------------------------+
module tx_frame_serializer
   import tx_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic              bit_tick,
   output logic              count_enable,
   output logic              serial_out,
   output logic              busy,
   output logic              frame_done
);

   localparam int              IDX_W       = $clog2(DATA_W);
   localparam logic [IDX_W-1:0] C_LAST_IDX  = IDX_W'(DATA_W - 1);
   localparam logic             C_LAST_STOP = 1'(STOP_BITS - 1);

   tx_state_t         r_state;
   tx_state_t         w_state_nxt;
   logic [DATA_W-1:0] r_shift;
   logic [IDX_W-1:0]  r_bit_idx;
   logic              r_stop_cnt;
   logic              r_parity;
   logic              r_serial;
   logic              r_count_en;
   logic              r_busy;
   logic              r_frame_done;

   logic              w_hold_full;
   logic [DATA_W-1:0] w_hold_data;
   logic              w_pop;
   logic              w_shift;
   logic              w_done;
   logic              w_idx_clr;
   logic              w_stop_clr;
   logic              w_stop_inc;
   logic              w_line;

   tx_hold_reg #(
      .DATA_W (DATA_W)
   ) u_hold (
      .clk     (clk),
      .reset   (reset),
      .i_data  (tx_data),
      .i_valid (tx_valid),
      .o_ready (tx_ready),
      .i_pop   (w_pop),
      .o_full  (w_hold_full),
      .o_data  (w_hold_data)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // w_line is the level of the bit currently in progress; it reaches the pin one cycle later.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_shift     = 1'b0;
      w_done      = 1'b0;
      w_idx_clr   = 1'b0;
      w_stop_clr  = 1'b0;
      w_stop_inc  = 1'b0;
      w_line      = LINE_IDLE;
      case (r_state)
         IDLE: begin
            if (w_hold_full) begin
               w_pop       = 1'b1;
               w_state_nxt = START;
            end
         end
         START: begin
            w_line = START_BIT;
            if (bit_tick) begin
               w_idx_clr   = 1'b1;
               w_state_nxt = DATA;
            end
         end
         DATA: begin
            w_line = r_shift[0];
            if (bit_tick) begin
               w_shift = 1'b1;
               if (r_bit_idx == C_LAST_IDX) begin
                  w_stop_clr  = (PARITY_EN == 0);
                  w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
               end
            end
         end
         PARITY: begin
            w_line = r_parity;
            if (bit_tick) begin
               w_stop_clr  = 1'b1;
               w_state_nxt = STOP;
            end
         end
         STOP: begin
            w_line = STOP_BIT;
            if (bit_tick) begin
               if (r_stop_cnt == C_LAST_STOP) begin
                  w_done = 1'b1;
                  if (w_hold_full) begin
                     w_pop       = 1'b1;
                     w_state_nxt = START;
                  end else begin
                     w_state_nxt = IDLE;
                  end
               end else begin
                  w_stop_inc = 1'b1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_shift      <= '0;
         r_bit_idx    <= '0;
         r_stop_cnt   <= 1'b0;
         r_parity     <= 1'b0;
         r_serial     <= LINE_IDLE;
         r_count_en   <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         if (w_pop) begin
            r_shift  <= w_hold_data;
            r_parity <= (^w_hold_data) ^ (PARITY_ODD != 0);
         end else if (w_shift) begin
            r_shift <= r_shift >> 1;
         end
         if (w_idx_clr) begin
            r_bit_idx <= '0;
         end else if (w_shift && (r_bit_idx != C_LAST_IDX)) begin
            r_bit_idx <= r_bit_idx + 1'b1;
         end
         if (w_stop_clr) begin
            r_stop_cnt <= 1'b0;
         end else if (w_stop_inc) begin
            r_stop_cnt <= 1'b1;
         end
         r_serial     <= w_line;
         r_count_en   <= (w_state_nxt != IDLE);
         r_busy       <= (w_state_nxt != IDLE);
         r_frame_done <= w_done;
      end
   end

   assign serial_out   = r_serial;
   assign count_enable = r_count_en;
   assign busy         = r_busy;
   assign frame_done   = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_tx_frame_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tx_frame_serializer : three configurations (8N1, 8E1, 8O2) driven  |
// | in parallel against a frame-queue reference model. Rev 1.0            |
// +----------------------------------------------------------------------+
module tb_tx_frame_serializer;

   logic        clk = 1'b0;
   logic        reset;
   logic        bit_tick;
   logic [2:0]  tx_valid;
   logic [23:0] tx_data_bus;
   logic [2:0]  tx_ready;
   logic [2:0]  count_enable;
   logic [2:0]  serial_out;
   logic [2:0]  busy;
   logic [2:0]  frame_done;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      tx_frame_serializer #(
         .DATA_W     (8),
         .PARITY_EN  ((g == 0) ? 0 : 1),
         .PARITY_ODD ((g == 2) ? 1 : 0),
         .STOP_BITS  ((g == 2) ? 2 : 1)
      ) u_dut (
         .clk          (clk),
         .reset        (reset),
         .tx_data      (tx_data_bus[8*g +: 8]),
         .tx_valid     (tx_valid[g]),
         .tx_ready     (tx_ready[g]),
         .bit_tick     (bit_tick),
         .count_enable (count_enable[g]),
         .serial_out   (serial_out[g]),
         .busy         (busy[g]),
         .frame_done   (frame_done[g])
      );
   end

   int n_checks = 0;
   int n_errors = 0;

   // reference model: remaining bits of the frame on the wire, plus the hold slot
   logic [15:0] m_bits [3];
   int          m_n    [3];
   logic        m_hold [3];
   logic [7:0]  m_hd   [3];
   logic        m_line [3];
   logic        m_done [3];

   logic [7:0]  src_mem [3][64];
   int          src_wr  [3];
   int          src_rd  [3];

   logic [31:0] obs    [3];
   int          obs_n  [3];
   int          fd_cnt [3];
   logic        act    [3];

   int tick_period;
   bit valid_rand;
   int cyc;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input int i, input logic [7:0] d);
      src_mem[i][src_wr[i]] = d;
      src_wr[i]++;
   endtask

   task automatic clear_obs();
      for (int i = 0; i < 3; i++) begin
         obs[i]    = '0;
         obs_n[i]  = 0;
         fd_cnt[i] = 0;
      end
   endtask

   // frame as a list of line levels in transmission order
   task automatic build_frame(input int i, input logic [7:0] d, output logic [15:0] v, output int n);
      v = '0;
      n = 0;
      v[n] = 1'b0;
      n++;
      for (int k = 0; k < 8; k++) begin
         v[n] = d[k];
         n++;
      end
      if (i != 0) begin
         v[n] = (^d) ^ (i == 2);
         n++;
      end
      for (int s = 0; s < ((i == 2) ? 2 : 1); s++) begin
         v[n] = 1'b1;
         n++;
      end
   endtask

   task automatic model_step();
      logic acc;
      for (int i = 0; i < 3; i++) begin
         if (!reset) begin
            m_n[i]    = 0;
            m_hold[i] = 1'b0;
            m_line[i] = 1'b1;
            m_done[i] = 1'b0;
         end else begin
            acc       = tx_valid[i] && !m_hold[i];
            m_line[i] = (m_n[i] > 0) ? m_bits[i][0] : 1'b1;
            m_done[i] = 1'b0;
            if (m_n[i] > 0) begin
               if (bit_tick) begin
                  m_bits[i] = m_bits[i] >> 1;
                  m_n[i]--;
                  if (m_n[i] == 0) begin
                     m_done[i] = 1'b1;
                     if (m_hold[i]) begin
                        build_frame(i, m_hd[i], m_bits[i], m_n[i]);
                        m_hold[i] = 1'b0;
                     end
                  end
               end
            end else if (m_hold[i]) begin
               build_frame(i, m_hd[i], m_bits[i], m_n[i]);
               m_hold[i] = 1'b0;
            end
            if (acc) begin
               m_hold[i] = 1'b1;
               m_hd[i]   = tx_data_bus[8*i +: 8];
               src_rd[i]++;
            end
         end
      end
   endtask

   task automatic one_cycle();
      bit_tick = (tick_period > 0) ? ((cyc % tick_period) == 0) : ($urandom_range(3) == 0);
      for (int i = 0; i < 3; i++) begin
         tx_valid[i] = (src_rd[i] < src_wr[i]) && (!valid_rand || ($urandom_range(1) == 1));
         tx_data_bus[8*i +: 8] = (src_rd[i] < src_wr[i]) ? src_mem[i][src_rd[i]] : 8'($urandom);
      end
      @(posedge clk);
      for (int i = 0; i < 3; i++) act[i] = (m_n[i] > 0) && bit_tick && reset;
      model_step();
      cyc++;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check_value($sformatf("serial_out%0d", i),   32'(serial_out[i]),   32'(m_line[i]));
         check_value($sformatf("tx_ready%0d", i),     32'(tx_ready[i]),     32'(!m_hold[i]));
         check_value($sformatf("count_enable%0d", i), 32'(count_enable[i]), 32'(m_n[i] > 0));
         check_value($sformatf("busy%0d", i),         32'(busy[i]),         32'(m_n[i] > 0));
         check_value($sformatf("frame_done%0d", i),   32'(frame_done[i]),   32'(m_done[i]));
         if (act[i] && obs_n[i] < 32) begin
            obs[i][obs_n[i]] = serial_out[i];
            obs_n[i]++;
         end
         if (frame_done[i]) fd_cnt[i]++;
      end
   endtask

   function automatic bit drained();
      drained = 1'b1;
      for (int i = 0; i < 3; i++)
         if (src_rd[i] < src_wr[i] || m_n[i] > 0 || m_hold[i]) drained = 1'b0;
   endfunction

   initial begin
      bit hit;
      reset       = 1'b0;
      bit_tick    = 1'b0;
      tx_valid    = '0;
      tx_data_bus = '0;
      cyc         = 0;
      tick_period = 0;
      valid_rand  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         m_bits[i] = '0;
         m_n[i]    = 0;
         m_hold[i] = 1'b0;
         m_hd[i]   = '0;
         m_line[i] = 1'b1;
         m_done[i] = 1'b0;
         src_wr[i] = 0;
         src_rd[i] = 0;
      end
      clear_obs();
      @(negedge clk);

      repeat (3) one_cycle();
      reset = 1'b1;
      repeat (20) one_cycle();

      // single frames, tick every 16 clocks
      clear_obs();
      tick_period = 16;
      cyc = 1;
      push(0, 8'hA5);
      push(1, 8'h07);
      push(2, 8'h07);
      repeat (260) one_cycle();
      check_value("bits_8n1_A5",  obs[0], 32'h34A);
      check_value("nbits_8n1",    32'(obs_n[0]), 32'd10);
      check_value("bits_8e1_07",  obs[1], 32'h60E);
      check_value("nbits_8e1",    32'(obs_n[1]), 32'd11);
      check_value("bits_8o2_07",  obs[2], 32'hC0E);
      check_value("nbits_8o2",    32'(obs_n[2]), 32'd12);
      for (int i = 0; i < 3; i++) begin
         check_value($sformatf("single_frame_done_cnt%0d", i), 32'(fd_cnt[i]), 32'd1);
         check_value($sformatf("single_cen_after%0d", i), 32'(count_enable[i]), 32'd0);
      end

      // back-to-back pair
      clear_obs();
      for (int i = 0; i < 3; i++) begin
         push(i, 8'h3C);
         push(i, 8'hC3);
      end
      repeat (520) one_cycle();
      check_value("bits_b2b_8n1", obs[0], 32'hE1A78);
      for (int i = 0; i < 3; i++)
         check_value($sformatf("b2b_frame_done_cnt%0d", i), 32'(fd_cnt[i]), 32'd2);

      // random bytes, random ticks, random valid gaps
      clear_obs();
      tick_period = 0;
      valid_rand  = 1'b1;
      for (int i = 0; i < 3; i++)
         for (int k = 0; k < 25; k++) push(i, 8'($urandom));
      hit = 1'b0;
      for (int c = 0; c < 6000 && !hit; c++) begin
         one_cycle();
         hit = drained();
      end
      check_value("random_drain_in_budget", 32'(hit), 32'd1);
      for (int i = 0; i < 3; i++)
         check_value($sformatf("random_frame_done_cnt%0d", i), 32'(fd_cnt[i]), 32'd25);

      // reset in the middle of data bit 3 with a byte waiting in the hold slot
      clear_obs();
      valid_rand  = 1'b0;
      tick_period = 8;
      push(0, 8'h55);
      push(0, 8'hAA);
      hit = 1'b0;
      for (int c = 0; c < 400 && !hit; c++) begin
         if (m_n[0] == 6) begin
            check_value("hold_full_before_reset", 32'(tx_ready[0]), 32'd0);
            reset = 1'b0;
            one_cycle();
            reset = 1'b1;
            hit = 1'b1;
         end else begin
            one_cycle();
         end
      end
      check_value("reset_window_reached", 32'(hit), 32'd1);
      repeat (100) one_cycle();
      check_value("no_frame_done_after_reset", 32'(fd_cnt[0]), 32'd0);
      check_value("idle_line_after_reset",     32'(serial_out[0]), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
